// File: rtl/pbvi_backup_step2_pkg.sv
// Shared definitions for the PBVI backup step-2 slice: sizes, address
// widths, FSM state encoding and the projection-address helper.
package pbvi_pkg;

  localparam int unsigned NUM_S = 2;
  localparam int unsigned NUM_A = 3;
  localparam int unsigned NUM_O = 2;
  localparam int unsigned NUM_V = 16;
  localparam int unsigned NUM_B = 16;
  localparam int unsigned W     = 16;

  localparam int unsigned A_W  = $clog2(NUM_A);
  localparam int unsigned O_W  = $clog2(NUM_O);
  localparam int unsigned V_W  = $clog2(NUM_V);
  localparam int unsigned B_AW = $clog2(NUM_B);
  localparam int unsigned P_AW = $clog2(NUM_A * NUM_O * NUM_V);
  localparam int unsigned G_AW = $clog2(NUM_A * NUM_B);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_B   = 4'd1,
    ST_LD_B_W = 4'd2,
    ST_INIT   = 4'd3,
    ST_SCAN   = 4'd4,
    ST_DRAIN  = 4'd5,
    ST_ACC    = 4'd6,
    ST_WRITE  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  // Flat projection-store index for (a, o, v): (a*NUM_O + o)*NUM_V + v
  function automatic logic [P_AW-1:0] proj_addr(input logic [A_W-1:0] a,
                                                input logic [O_W-1:0] o,
                                                input logic [V_W-1:0] v);
    return P_AW'((int'(a) * int'(NUM_O) + int'(o)) * int'(NUM_V) + int'(v));
  endfunction

endpackage

// File: rtl/pbvi_dot_argmax.sv
// Streaming two-term dot product with a strict-greater running maximum.
// clear forgets the current best; the first valid candidate after clear is
// always taken, later ones only when their dot product is strictly larger,
// so ties keep the earliest candidate.
module pbvi_dot_argmax
  import pbvi_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         valid,
  input  logic [W-1:0] b_s0,
  input  logic [W-1:0] b_s1,
  input  logic [W-1:0] p_s0,
  input  logic [W-1:0] p_s1,
  output logic [W-1:0] best_s0,
  output logic [W-1:0] best_s1
);

  logic [2*W-1:0] w_prod0;
  logic [2*W-1:0] w_prod1;
  logic [2*W:0]   w_dot;
  logic           w_take;

  logic [2*W:0]   r_best_dot;
  logic           r_have;
  logic [W-1:0]   r_best_s0;
  logic [W-1:0]   r_best_s1;

  // Full-precision products and their sum, no truncation
  assign w_prod0 = (2*W)'(b_s0) * (2*W)'(p_s0);
  assign w_prod1 = (2*W)'(b_s1) * (2*W)'(p_s1);
  assign w_dot   = (2*W+1)'(w_prod0) + (2*W+1)'(w_prod1);
  assign w_take  = valid && (!r_have || (w_dot > r_best_dot));

  // Running maximum over the candidates presented since the last clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_best_dot <= '0;
      r_have     <= 1'b0;
      r_best_s0  <= '0;
      r_best_s1  <= '0;
    end else if (clear) begin
      r_best_dot <= '0;
      r_have     <= 1'b0;
    end else if (w_take) begin
      r_best_dot <= w_dot;
      r_have     <= 1'b1;
      r_best_s0  <= p_s0;
      r_best_s1  <= p_s1;
    end else begin
      r_best_dot <= r_best_dot;
      r_have     <= r_have;
    end
  end

  assign best_s0 = r_best_s0;
  assign best_s1 = r_best_s1;

endmodule

// File: rtl/pbvi_backup_step2.sv
// Point-based backup: for every belief b and action a builds
// gamma = r_a + sum_o argmax_v (b . proj[a][o][v]) and writes it to the
// gamma store at a*NUM_B+b. One projection read per cycle.
// Optional build macro PBVI_STEP2_SAT_EN: saturate each accumulated
// component at all-ones instead of wrapping modulo 2^W.
module pbvi_backup_step2
  import pbvi_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_A*NUM_S*W-1:0] rewards,
  output logic [B_AW-1:0]          b_rd_addr,
  input  logic [W-1:0]             b_rd_s0,
  input  logic [W-1:0]             b_rd_s1,
  output logic [P_AW-1:0]          p_rd_addr,
  input  logic [W-1:0]             p_rd_s0,
  input  logic [W-1:0]             p_rd_s1,
  output logic                     wr_en,
  output logic [G_AW-1:0]          wr_addr,
  output logic [W-1:0]             wr_s0,
  output logic [W-1:0]             wr_s1,
  output logic                     busy,
  output logic                     done
);

  localparam logic [A_W-1:0]  A_LAST = A_W'(NUM_A - 1);
  localparam logic [O_W-1:0]  O_LAST = O_W'(NUM_O - 1);
  localparam logic [V_W-1:0]  V_LAST = V_W'(NUM_V - 1);
  localparam logic [B_AW-1:0] B_LAST = B_AW'(NUM_B - 1);

  state_t          r_state;
  logic [B_AW-1:0] r_b;
  logic [A_W-1:0]  r_a;
  logic [O_W-1:0]  r_o;
  logic [V_W-1:0]  r_v;
  logic [W-1:0]    r_bel_s0;
  logic [W-1:0]    r_bel_s1;
  logic [W-1:0]    r_acc_s0;
  logic [W-1:0]    r_acc_s1;
  logic [B_AW-1:0] r_b_rd_addr;
  logic [P_AW-1:0] r_p_rd_addr;
  logic            r_wr_en;
  logic [G_AW-1:0] r_wr_addr;
  logic [W-1:0]    r_wr_s0;
  logic [W-1:0]    r_wr_s1;
  logic            r_busy;
  logic            r_done;

  logic [W-1:0]    w_rew_s0;
  logic [W-1:0]    w_rew_s1;
  logic [W-1:0]    w_best_s0;
  logic [W-1:0]    w_best_s1;
  logic [W-1:0]    w_add_s0;
  logic [W-1:0]    w_add_s1;
  logic            w_clear;
  logic            w_valid;

  // Reward of the current action, packed {s1,s0} per action
  assign w_rew_s0 = rewards[int'(r_a) * 2 * int'(W) +: W];
  assign w_rew_s1 = rewards[int'(r_a) * 2 * int'(W) + int'(W) +: W];

  // Data for address v arrives while v+1 is issued: the v=0 issue cycle has
  // nothing to compare and restarts the max; DRAIN compares the last vector.
  assign w_clear = (r_state == ST_SCAN) && (r_v == '0);
  assign w_valid = ((r_state == ST_SCAN) && (r_v != '0)) || (r_state == ST_DRAIN);

  pbvi_dot_argmax u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .valid   (w_valid),
    .b_s0    (r_bel_s0),
    .b_s1    (r_bel_s1),
    .p_s0    (p_rd_s0),
    .p_s1    (p_rd_s1),
    .best_s0 (w_best_s0),
    .best_s1 (w_best_s1)
  );

`ifdef PBVI_STEP2_SAT_EN
  logic [W:0] w_sum_s0;
  logic [W:0] w_sum_s1;
  assign w_sum_s0 = {1'b0, r_acc_s0} + {1'b0, w_best_s0};
  assign w_sum_s1 = {1'b0, r_acc_s1} + {1'b0, w_best_s1};
  assign w_add_s0 = w_sum_s0[W] ? {W{1'b1}} : w_sum_s0[W-1:0];
  assign w_add_s1 = w_sum_s1[W] ? {W{1'b1}} : w_sum_s1[W-1:0];
`else
  // Carry out of the W-bit add is dropped: modulo-2^W wrap
  assign w_add_s0 = r_acc_s0 + w_best_s0;
  assign w_add_s1 = r_acc_s1 + w_best_s1;
`endif

  // Control FSM with loop counters, accumulators and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_b         <= '0;
      r_a         <= '0;
      r_o         <= '0;
      r_v         <= '0;
      r_bel_s0    <= '0;
      r_bel_s1    <= '0;
      r_acc_s0    <= '0;
      r_acc_s1    <= '0;
      r_b_rd_addr <= '0;
      r_p_rd_addr <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_s0     <= '0;
      r_wr_s1     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_b         <= '0;
            r_b_rd_addr <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_LD_B;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LD_B: begin
          r_state <= ST_LD_B_W;
        end
        ST_LD_B_W: begin
          r_bel_s0 <= b_rd_s0;
          r_bel_s1 <= b_rd_s1;
          r_a      <= '0;
          r_state  <= ST_INIT;
        end
        ST_INIT: begin
          r_acc_s0    <= w_rew_s0;
          r_acc_s1    <= w_rew_s1;
          r_o         <= '0;
          r_v         <= '0;
          r_p_rd_addr <= proj_addr(r_a, '0, '0);
          r_state     <= ST_SCAN;
        end
        ST_SCAN: begin
          if (r_v == V_LAST) begin
            r_state <= ST_DRAIN;
          end else begin
            r_v         <= r_v + V_W'(1);
            r_p_rd_addr <= proj_addr(r_a, r_o, r_v + V_W'(1));
          end
        end
        ST_DRAIN: begin
          r_state <= ST_ACC;
        end
        ST_ACC: begin
          r_acc_s0 <= w_add_s0;
          r_acc_s1 <= w_add_s1;
          if (r_o == O_LAST) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= G_AW'(int'(r_a) * int'(NUM_B) + int'(r_b));
            r_wr_s0   <= w_add_s0;
            r_wr_s1   <= w_add_s1;
            r_state   <= ST_WRITE;
          end else begin
            r_o         <= r_o + O_W'(1);
            r_v         <= '0;
            r_p_rd_addr <= proj_addr(r_a, r_o + O_W'(1), '0);
            r_state     <= ST_SCAN;
          end
        end
        ST_WRITE: begin
          if (r_a != A_LAST) begin
            r_a     <= r_a + A_W'(1);
            r_state <= ST_INIT;
          end else if (r_b != B_LAST) begin
            r_b         <= r_b + B_AW'(1);
            r_b_rd_addr <= r_b + B_AW'(1);
            r_state     <= ST_LD_B;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign b_rd_addr = r_b_rd_addr;
  assign p_rd_addr = r_p_rd_addr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_s0     = r_wr_s0;
  assign wr_s1     = r_wr_s1;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/pbvi_backup_step2.md
Name: pbvi_backup_step2

Overview:
- Point-based backup stage directly upstream of the best-action selector.
- For every belief point b and action a, it builds the backed-up vector gamma_a_b = r_a + sum over observations o of argmax over v of (b · proj[a][o][v]).
- It writes each result into the gamma_a_b store at index a*NUM_B+b, which the best-action selector then consumes.
- Sequential scan: one projected-vector read per cycle, with a streaming dot-product argmax.

Parameters:
NUM_S, 2, state count (fixed at 2; the datapath carries s0/s1 explicitly)
NUM_A, 3, actions
NUM_O, 2, observations
NUM_V, 16, alpha vectors in the current set (projections per (a,o))
NUM_B, 16, belief points
W, 16, word width of beliefs, rewards and vector components (unsigned)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a full backup pass
rewards  in  NUM_A*2*W  r_a packed as {s1,s0} per action; slice a at [a*2W +: 2W]
b_rd_addr  out  $clog2(NUM_B)  belief read address
b_rd_s0, b_rd_s1  in  W each  belief data, valid the cycle after the address
p_rd_addr  out  $clog2(NUM_A*NUM_O*NUM_V)  projection address = (a*NUM_O+o)*NUM_V+v
p_rd_s0, p_rd_s1  in  W each  projection data, 1-cycle read latency
wr_en  out  1  gamma_a_b write strobe
wr_addr  out  $clog2(NUM_A*NUM_B)  a*NUM_B+b
wr_s0, wr_s1  out  W each  backed-up vector
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: state=IDLE; busy, done, wr_en = 0; all addresses, wr_s0/wr_s1 and accumulators = 0. Applies mid-pass too: the pass aborts and no further writes occur.
- Loop order: b outer, a, o, v inner. Write sequence: 0, 16, 32, 1, 17, 33, ...
- FSM states:
  - IDLE: start=1 -> LD_B with b=0. start is ignored in all other states.
  - LD_B (1 cycle): drive b_rd_addr.
  - LD_B_W (1 cycle): capture the belief; a=0.
  - INIT (1 cycle): acc <= r_a; o=0.
  - SCAN (NUM_V cycles): issue p_rd_addr for v=0..NUM_V-1. In the same cycle, compare the data returned for v-1.
  - DRAIN (1 cycle): compare v=NUM_V-1.
  - ACC (1 cycle): acc <= acc + best; next o -> SCAN, else -> WRITE.
  - WRITE (1 cycle): wr_en=1 with acc. Next a -> INIT; else next b -> LD_B; else -> DONE.
  - DONE (1 cycle): done=1, busy falls, -> IDLE.
- busy is high from the cycle after start through DONE.
- Busy length = NUM_B*(2+NUM_A*(2+NUM_O*(NUM_V+2))) cycles before DONE (1856 for defaults).
- Dot product: b_s0*p_s0 + b_s1*p_s1, full 2W+1-bit unsigned, no truncation.
- Argmax: the first candidate (v=0) is always taken. A later v replaces it only on strictly greater value, so ties keep the lowest v.
- Accumulation is per component, W+1 bits internally. Overflow handling is governed by the optional feature below.

Optional Feature:
PBVI_STEP2_SAT_EN
- Defined: each component result clamps to {W{1'b1}} when the sum exceeds 2^W-1.
- Undefined: modulo-2^W wrap.

Decomposition:
- Shared package pbvi_pkg: FSM state enum; W/NUM_* defaults; address-width localparams; helper function for the projection address.
- Sub-module pbvi_dot_argmax: streaming 2-term dot product plus strict-greater running max. It has clear/valid inputs, outputs best_s0/best_s1, and is reused by the best-action selector.

Test Plan:
- Tie-break: belief (0x8000,0x8000), proj v0=(1,3) and v1=(3,1), all other v=(0,0), rewards 0 -> each (a,b) writes (2,6); v0 is kept on the equal dot product 0x20000.
- Sum path: rewards (5,5) for all a, all projections (1,3) -> all 48 writes = (7,11).
- Overflow: r_0=(0xFFF0,0), every proj=(0x10,0) -> wr_s0=0xFFFF with PBVI_STEP2_SAT_EN, 0x0010 without.
- Timing/order: defaults -> exactly 48 wr_en pulses at addresses 0,16,32,1,17,33,…,47; done exactly once, 1856 busy cycles after start.
- Reset mid-pass: rst_n low at busy cycle 500 -> busy=0 next cycle and no writes. A subsequent start completes a full 1856-cycle pass.
- start pulsed while busy -> ignored; write count and done timing unchanged.
